// File: rtl/modred_pkg.sv
// modred_pkg: shared state encoding, default widths and counter sizing for the modular reducer
package modred_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_PW = 48;
  localparam int DEF_MW = 24;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
  localparam int CNT_W = cnt_w(DEF_PW);
endpackage

// File: rtl/modred_step.sv
// modred_step: one restoring shift/compare/subtract step of binary long division
module modred_step #(
  parameter int MW = 24
) (
  input  logic [MW:0]   r,
  input  logic          b,
  input  logic [MW-1:0] m,
  output logic [MW:0]   r_nx,
  output logic          q_bit
);
  logic [MW+1:0] t;
  logic          ge;
  assign t     = {r, b};
  assign ge    = t >= {2'b00, m};
  assign q_bit = ge;
  assign r_nx  = ge ? (MW+1)'(t - {2'b00, m}) : t[MW:0];
endmodule

// File: rtl/modred48_seq.sv
// modred48_seq: bit-serial P mod M reducer with valid/ready on both sides; MODRED_QUOTIENT_EN adds the Q quotient port
module modred48_seq
  import modred_pkg::*;
#(
  parameter int PW = DEF_PW,
  parameter int MW = DEF_MW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] P,
  input  logic [MW-1:0] M,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] R,
  output logic          err
`ifdef MODRED_QUOTIENT_EN
  ,
  output logic [PW-1:0] Q
`endif
);
  localparam int CW = cnt_w(PW);
  state_t        state, state_nx;
  logic [PW-1:0] p_sh;
  logic [MW-1:0] m_r;
  logic [MW:0]   r, r_nx;
  logic [CW-1:0] cnt;
  logic          err_r;
  logic          accept;
`ifdef MODRED_QUOTIENT_EN
  logic [PW-1:0] q_sh;
  logic          q_bit;
`else
  logic          unused_q_bit;
`endif
  modred_step #(.MW(MW)) u_step (
    .r    (r),
    .b    (p_sh[PW-1]),
    .m    (m_r),
    .r_nx (r_nx),
`ifdef MODRED_QUOTIENT_EN
    .q_bit(q_bit)
`else
    .q_bit(unused_q_bit)
`endif
  );
  // handshakes and next state; a result can be consumed and a new pair accepted in one cycle
  always_comb begin
    in_ready  = state == IDLE || (state == DONE && out_ready);
    out_valid = state == DONE;
    accept    = in_valid && in_ready;
    state_nx  = accept ? (M == '0 ? DONE : RUN)
              : (state == RUN && cnt == '0) ? DONE
              : (state == DONE && out_ready) ? IDLE : state;
  end
  // state register plus operand latch on accept and one division step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p_sh  <= '0;
      m_r   <= '0;
      r     <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
`ifdef MODRED_QUOTIENT_EN
      q_sh  <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        p_sh  <= P;
        m_r   <= M;
        r     <= '0;
        cnt   <= CW'(PW - 1);
        err_r <= M == '0;
`ifdef MODRED_QUOTIENT_EN
        q_sh  <= '0;
`endif
      end else if (state == RUN) begin
        r    <= r_nx;
        p_sh <= {p_sh[PW-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
`ifdef MODRED_QUOTIENT_EN
        q_sh <= {q_sh[PW-2:0], q_bit};
`endif
      end
    end
  end
  assign R   = r[MW-1:0];
  assign err = err_r;
`ifdef MODRED_QUOTIENT_EN
  assign Q = q_sh;
`endif
endmodule

// File: tb/tb_modred48_seq.sv
// tb_modred48_seq: scoreboard bench for modred48_seq; compile with MODRED_QUOTIENT_EN to also check Q
module tb_modred48_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [47:0] P;
  logic [23:0] M, R;
`ifdef MODRED_QUOTIENT_EN
  logic [47:0] Q;
`endif
  typedef struct packed {logic [23:0] r; logic e; logic [47:0] q;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  modred48_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .P(P), .M(M),
    .out_valid(out_valid), .out_ready(out_ready), .R(R), .err(err)
`ifdef MODRED_QUOTIENT_EN
    , .Q(Q)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [47:0] p, input logic [23:0] m);
    exp_t x;
    x.e = m == '0;
    x.r = '0;
    x.q = '0;
    if (!x.e) begin
      x.r = 24'(p % {24'd0, m});
      x.q = p / {24'd0, m};
    end
    sb.push_back(x);
  endtask

  task automatic drive(input logic [47:0] p, input logic [23:0] m);
    P = p;
    M = m;
    in_valid = 1'b1;
    push(p, m);
    for (int i = 0; i < 200 && !in_ready; i++) tick();
    tick();
    in_valid = 1'b0;
    P = 48'(~p);
    M = 24'(~m);
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic pop(output exp_t x);
    x = '0;
    if (sb.size() != 0) x = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    total++; if (R !== 24'd0) begin bad++; $display("FAIL reset R got %h want 0", R); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset err got %b want 0", err); end
`ifdef MODRED_QUOTIENT_EN
    total++; if (Q !== 48'd0) begin bad++; $display("FAIL reset Q got %h want 0", Q); end
`endif
  endtask

  task automatic test_square();
    int n;
    exp_t x;
    drive(48'hFFFFFE000001, 24'hFFFFFF);
    wait_ov(n);
    pop(x);
    total++; if (n != 48) begin bad++; $display("FAIL square latency got %0d want 48", n); end
    total++; if (R !== x.r) begin bad++; $display("FAIL square R got %h want %h", R, x.r); end
    total++; if (err !== x.e) begin bad++; $display("FAIL square err got %b want %b", err, x.e); end
`ifdef MODRED_QUOTIENT_EN
    total++; if (Q !== x.q) begin bad++; $display("FAIL square Q got %h want %h", Q, x.q); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL square idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_small();
    int n;
    exp_t x;
    logic [47:0] pr;
    pr = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    drive(48'd1000, 24'd7);
    wait_ov(n);
    pop(x);
    total++; if (R !== x.r || x.r !== 24'd6) begin bad++; $display("FAIL small R got %0d want %0d", R, x.r); end
`ifdef MODRED_QUOTIENT_EN
    total++; if (Q !== x.q) begin bad++; $display("FAIL small Q got %0d want %0d", Q, x.q); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drive(pr, 24'd1);
    wait_ov(n);
    pop(x);
    total++; if (n != 48) begin bad++; $display("FAIL m1 latency got %0d want 48", n); end
    total++; if (R !== x.r || err !== 1'b0) begin bad++; $display("FAIL m1 R/err got %h/%b want %h/0", R, err, x.r); end
`ifdef MODRED_QUOTIENT_EN
    total++; if (Q !== x.q) begin bad++; $display("FAIL m1 Q got %h want %h", Q, x.q); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_zero();
    int n;
    exp_t x;
    drive(48'h123456789ABC, 24'd0);
    wait_ov(n);
    pop(x);
    total++; if (n != 0) begin bad++; $display("FAIL zero latency got %0d want 0 extra edges", n); end
    total++; if (err !== x.e || R !== x.r) begin bad++; $display("FAIL zero err/R got %b/%h want %b/%h", err, R, x.e, x.r); end
`ifdef MODRED_QUOTIENT_EN
    total++; if (Q !== x.q) begin bad++; $display("FAIL zero Q got %h want %h", Q, x.q); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    exp_t x;
    out_ready = 1'b1;
    drive(48'd1000, 24'd7);
    wait_ov(n1);
    pop(x);
    total++; if (n1 != 48) begin bad++; $display("FAIL b2b first latency got %0d want 48", n1); end
    total++; if (R !== x.r) begin bad++; $display("FAIL b2b first R got %h want %h", R, x.r); end
    P = 48'h123456789ABC;
    M = 24'h800000;
    in_valid = 1'b1;
    push(P, M);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b in_ready in DONE got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    M = 24'd3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b out_valid after accept got %b want 0", out_valid); end
    wait_ov(n2);
    pop(x);
    total++; if (n2 + 1 != 49) begin bad++; $display("FAIL b2b spacing got %0d want 49", n2 + 1); end
    total++; if (R !== x.r || x.r !== 24'h789ABC) begin bad++; $display("FAIL b2b second R got %h want %h", R, x.r); end
`ifdef MODRED_QUOTIENT_EN
    total++; if (Q !== x.q) begin bad++; $display("FAIL b2b second Q got %h want %h", Q, x.q); end
`endif
    P = 48'hABCDEF;
    M = 24'd0;
    in_valid = 1'b1;
    push(P, M);
    tick();
    in_valid = 1'b0;
    pop(x);
    total++; if (out_valid !== 1'b1 || err !== x.e || R !== x.r) begin bad++; $display("FAIL b2b err ov/err/R got %b/%b/%h want 1/%b/%h", out_valid, err, R, x.e, x.r); end
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b idle ov/in_ready got %b/%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_stall();
    int n;
    exp_t x;
    drive(48'd1000, 24'd7);
    wait_ov(n);
    pop(x);
    for (int i = 0; i < 5; i++) begin
      P = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      M = 24'($urandom());
      in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall in_ready cyc %0d got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || R !== x.r || err !== x.e) begin bad++; $display("FAIL stall hold cyc %0d ov/R/err got %b/%h/%b want 1/%h/%b", i, out_valid, R, err, x.r, x.e); end
`ifdef MODRED_QUOTIENT_EN
      total++; if (Q !== x.q) begin bad++; $display("FAIL stall Q cyc %0d got %h want %h", i, Q, x.q); end
`endif
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sb.size() != 0) begin bad++; $display("FAIL stall release ov/in_ready got %b/%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int n, seen;
    exp_t x;
    drive(48'd1000, 24'd7);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst idle in_ready/ov got %b/%b want 1/0", in_ready, out_valid); end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst spurious out_valid cycles got %0d want 0", seen); end
    drive(48'd1000, 24'd7);
    wait_ov(n);
    pop(x);
    total++; if (n != 48 || R !== 24'd6 || R !== x.r) begin bad++; $display("FAIL midrst fresh lat/R got %0d/%0d want 48/%0d", n, R, x.r); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    P = '0;
    M = '0;
    test_reset();
    test_square();
    test_small();
    test_zero();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
